mem_burst_responder: RTL and testbench
======================================

MEM_BURST_RESPONDER -- requirements
Module: mem_burst_responder

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4: maximum backing-bus reads in flight, power of two, 1..16.
REQ-002 SHALL have port clk, input, 1: single clock; every register uses its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port mem_request, input, 1: master burst-read request, held high until acked.
REQ-005 SHALL have port mem_addr, input, 30: word address of the requested word.
REQ-006 SHALL have port mem_rlen, input, 5: burst length minus 1; rlen+1 SHALL be a power of two.
REQ-007 SHALL have port mem_ack, output, 1: one-cycle acceptance pulse.
REQ-008 SHALL have port mem_rvalid, output, 1: returned burst word valid; the master cannot stall it.
REQ-009 SHALL have port mem_rdata, output, 32: returned burst word.
REQ-010 SHALL have port bus_rd, output, 1: backing word-read request.
REQ-011 SHALL have port bus_addr, output, 30: backing word address.
REQ-012 SHALL have port bus_ready, input, 1: a read transfers when bus_rd & bus_ready.
REQ-013 SHALL have port bus_rvalid, input, 1: backing read data valid, in order, any latency of 1 or more cycles.
REQ-014 SHALL have port bus_rdata, input, 32: backing read data.
REQ-015 SHALL have port spurious_rvalid, output, 1: sticky error flag.

Function
REQ-016 States SHALL be IDLE, ACK, BURST.
- IDLE & mem_request -> ACK.
- ACK -> BURST unconditionally.
- BURST -> IDLE on the cycle the last word is registered onto mem_rvalid.
REQ-017 On leaving IDLE, SHALL latch base = mem_addr with its low bits cleared (mem_addr & ~rlen, rlen zero-extended), and latch len = mem_rlen.
REQ-018 mem_ack SHALL be registered and high exactly in the ACK cycle: request sampled in cycle N gives ack in cycle N+1.
REQ-019 mem_request SHALL be ignored in ACK and BURST.
REQ-020 Reads SHALL issue in ACK and BURST; bus_rd = (issued <= len) & (outstanding < MAX_OUTSTANDING).
REQ-021 bus_addr SHALL equal base + issued, modulo 2^30; consecutive addresses are ascending and line-aligned.
REQ-022 The outstanding counter SHALL add 1 per accepted read and subtract 1 per bus_rvalid; both in one cycle leaves it unchanged.
REQ-023 mem_rvalid/mem_rdata SHALL be the registered bus_rvalid/bus_rdata, one cycle later, while in ACK or BURST.
REQ-024 Returned-word counter: incremented per accepted bus_rvalid; completion when bus_rvalid & returned == len.
REQ-025 The issued counter SHALL be 6 bits wide so that len = 31 (32 words) does not alias.
REQ-026 bus_rvalid in IDLE, or beyond len+1 words, SHALL be dropped (no mem_rvalid) and SHALL set spurious_rvalid until reset.
REQ-027 rlen = 0 SHALL produce exactly one word, at address mem_addr.
REQ-028 Throughput: with bus_ready = 1 and latency below MAX_OUTSTANDING, SHALL sustain one word per cycle.
REQ-029 Minimum request-to-first-rvalid latency SHALL be bus latency + 2 cycles.

Reset
REQ-030 rst SHALL force state to IDLE and clear all counters.
REQ-031 rst SHALL clear mem_ack, mem_rvalid, bus_rd and spurious_rvalid to 0.
REQ-032 rst SHALL clear mem_rdata, bus_addr, base and len to 0.
REQ-033 Reset mid-burst SHALL abandon the burst; backing data arriving after reset is spurious per REQ-026, and system integration guarantees none arrives.

Structure
REQ-034 The burst-length width (5) and the word-address width (30) SHALL be constants in cva5_types, shared with the cache masters.
REQ-035 The state enum SHALL be local to the module.
REQ-036 No sub-module is required.
REQ-037 An outstanding-tag FIFO SHALL be unnecessary, because responses are in order.

Verification
REQ-038 Aligned burst:
- Stimulus: addr = 0x100, rlen = 7, bus_ready = 1, latency 1.
- Required: ack at cycle 1; bus_addr 0x100..0x107 in cycles 1..8; eight back-to-back mem_rvalid with data matching memory; return to IDLE.
REQ-039 Unaligned request:
- Stimulus: addr = 0x10D, rlen = 7.
- Required: reads start at 0x108 and the first mem_rdata equals mem[0x108].
REQ-040 Outstanding limit:
- Stimulus: latency 6, MAX_OUTSTANDING = 4, rlen = 15.
- Required: bus_rd never accepted with 4 in flight; all 16 words return in order.
REQ-041 Backpressure:
- Stimulus: bus_ready toggling 1/0 each cycle, rlen = 3.
- Required: 4 reads issued only on ready cycles; exactly 4 mem_rvalid.
REQ-042 Boundaries:
- rlen = 31 -> exactly 32 words.
- rlen = 0 -> one word, at addr 0x3FFFFFFF.
- Single bus_rvalid injected in IDLE -> spurious_rvalid = 1 and no mem_rvalid.
REQ-043 Reset in BURST after 3 of 8 words:
- Required: next cycle all outputs are 0 and state is IDLE.
- A new request then completes normally.

Source files
------------

// File: rtl/mem_burst_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Packages : cva5_types, mem_burst_responder_pkg                             |
// | Purpose  : cva5_types holds the burst-length and word-address widths that  |
// |            every cache master shares. mem_burst_responder_pkg builds the   |
// |            responder's datapath types and the burst alignment helper on    |
// |            top of them.                                                    |
// | Ports    : none (packages only)                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package cva5_types;
  localparam int unsigned BURST_LEN_W = 5;
  localparam int unsigned WORD_ADDR_W = 30;
endpackage

package mem_burst_responder_pkg;
  import cva5_types::*;

  localparam int unsigned DATA_W  = 32;
  // One bit wider than the burst length, so that a count of 32 beats
  // stays distinct from a count of 0.
  localparam int unsigned BEAT_W  = BURST_LEN_W + 1;

  typedef logic [WORD_ADDR_W-1:0] word_addr_t;
  typedef logic [BURST_LEN_W-1:0] burst_len_t;
  typedef logic [DATA_W-1:0]      data_t;
  typedef logic [BEAT_W-1:0]      beat_cnt_t;

  // Bursts are line-aligned. rlen+1 is a power of two, so clearing the bits
  // set in rlen gives the start of the line that contains addr.
  function automatic word_addr_t burst_base(word_addr_t addr, burst_len_t rlen);
    return addr & ~word_addr_t'(rlen);
  endfunction
endpackage
`default_nettype wire

// File: rtl/mem_burst_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : mem_burst_responder_if                                         |
// | Purpose   : Groups the master-side burst-read port and the backing word    |
// |             bus that the responder uses.                                   |
// | Signals   : mem_request/mem_addr/mem_rlen -> responder,                    |
// |             mem_ack/mem_rvalid/mem_rdata  <- responder,                    |
// |             bus_rd/bus_addr <- responder,                                  |
// |             bus_ready/bus_rvalid/bus_rdata -> responder                    |
// | Modports  : slave  = the responder                                         |
// |             master = the surrounding system (cache master + backing bus)   |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface mem_burst_responder_if;
  import mem_burst_responder_pkg::*;

  logic       mem_request;
  word_addr_t mem_addr;
  burst_len_t mem_rlen;
  logic       mem_ack;
  logic       mem_rvalid;
  data_t      mem_rdata;

  logic       bus_rd;
  word_addr_t bus_addr;
  logic       bus_ready;
  logic       bus_rvalid;
  data_t      bus_rdata;

  modport slave (
    input  mem_request, mem_addr, mem_rlen, bus_ready, bus_rvalid, bus_rdata,
    output mem_ack, mem_rvalid, mem_rdata, bus_rd, bus_addr
  );

  modport master (
    output mem_request, mem_addr, mem_rlen, bus_ready, bus_rvalid, bus_rdata,
    input  mem_ack, mem_rvalid, mem_rdata, bus_rd, bus_addr
  );
endinterface
`default_nettype wire

// File: rtl/mem_burst_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mem_burst_responder                                             |
// | Purpose  : Accepts one line-aligned burst-read request at a time, splits   |
// |            it into single-word reads on the backing bus (at most           |
// |            MAX_OUTSTANDING in flight), and forwards the in-order returned  |
// |            words to the master one cycle after they arrive.                |
// | Ports    : clk, rst          - clock, synchronous active-high reset        |
// |            link (slave)      - master burst port + backing word bus        |
// |            spurious_rvalid   - sticky: backing data came with no burst     |
// |                                waiting for it                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mem_burst_responder
  import mem_burst_responder_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_burst_responder_if.slave  link,
  output logic                  spurious_rvalid
);

  // The in-flight counter has to hold MAX_OUTSTANDING itself, not just values below it.
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  word_addr_t         base;
  burst_len_t         len;
  beat_cnt_t          issued;
  beat_cnt_t          returned;
  logic [OUT_W-1:0]   outstanding;

  logic start;
  logic issue_ok;
  logic rd_fire;
  logic rv_accept;
  logic rv_last;

  assign start    = (state == IDLE) && link.mem_request;
  assign issue_ok = (issued <= beat_cnt_t'(len)) &&
                    (outstanding < OUT_W'(MAX_OUTSTANDING));
  assign rd_fire  = link.bus_rd && link.bus_ready;

  // Backing data is used only while a burst is still waiting for words.
  // Anything else is dropped and flagged.
  assign rv_accept = link.bus_rvalid && (state != IDLE) &&
                     (returned <= beat_cnt_t'(len));
  assign rv_last   = rv_accept && (returned == beat_cnt_t'(len));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    link.bus_rd   = 1'b0;
    link.bus_addr = base + word_addr_t'(issued);
    case (state)
      IDLE: begin
        if (link.mem_request) begin
          state_next = ACK;
        end
      end
      ACK: begin
        link.bus_rd = issue_ok;
        state_next  = BURST;
      end
      BURST: begin
        link.bus_rd = issue_ok;
        if (rv_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      link.mem_ack    <= 1'b0;
      link.mem_rvalid <= 1'b0;
      link.mem_rdata  <= '0;
      spurious_rvalid <= 1'b0;
      base            <= '0;
      len             <= '0;
      issued          <= '0;
      returned        <= '0;
      outstanding     <= '0;
    end else begin
      // start is only ever true in IDLE, so the registered pulse is high in exactly the ACK cycle.
      link.mem_ack    <= start;
      link.mem_rvalid <= rv_accept;
      if (rv_accept) begin
        link.mem_rdata <= link.bus_rdata;
      end
      if (link.bus_rvalid && !rv_accept) begin
        spurious_rvalid <= 1'b1;
      end

      if (start) begin
        base     <= burst_base(link.mem_addr, link.mem_rlen);
        len      <= link.mem_rlen;
        issued   <= '0;
        returned <= '0;
      end else begin
        if (rd_fire) begin
          issued <= issued + beat_cnt_t'(1);
        end
        if (rv_accept) begin
          returned <= returned + beat_cnt_t'(1);
        end
      end

      // Responses arrive in order, so a count is all the tracking needed.
      case ({rd_fire, rv_accept})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mem_burst_responder                                          |
// | Purpose  : Randomised scoreboard bench for mem_burst_responder. A memory   |
// |            and in-order backing-bus model supply the data. Expected read   |
// |            addresses and returned words are queued when a request is made  |
// |            and popped by independent monitors.                             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mem_burst_responder;
  import mem_burst_responder_pkg::*;

  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst;
  logic spurious_rvalid;

  mem_burst_responder_if ifc ();

  mem_burst_responder #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk             (clk),
    .rst             (rst),
    .link            (ifc.slave),
    .spurious_rvalid (spurious_rvalid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // bus model configuration
  int lat        = 1;
  int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
  bit jitter     = 1'b0;
  bit inject_spur = 1'b0;

  logic [29:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_data[$];
  logic [29:0] exp_addr[$];

  int rx_count, rx_first, rx_last, rd_count, max_inflight;

  function automatic logic [31:0] mem_word(logic [29:0] a);
    logic [31:0] w;
    w = {a, 2'b01};
    return (w * 32'h9E37_79B1) ^ 32'hC3A5_1F0E;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next_drive();
    @(posedge clk);
    #2;
  endtask

  // Backing bus: fixed latency per read, optional extra delay, always in order.
  initial begin
    int inflight;
    ifc.bus_ready  = 1'b0;
    ifc.bus_rvalid = 1'b0;
    ifc.bus_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      case (ready_mode)
        0:       ifc.bus_ready = 1'b1;
        1:       ifc.bus_ready = (cyc % 2 == 0);
        default: ifc.bus_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (inject_spur) begin
        ifc.bus_rvalid = 1'b1;
        ifc.bus_rdata  = 32'hDEAD_BEEF;
        inject_spur    = 1'b0;
      end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        ifc.bus_rvalid = 1'b1;
        ifc.bus_rdata  = mem_word(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        ifc.bus_rvalid = 1'b0;
        ifc.bus_rdata  = $urandom;
      end
      @(negedge clk);
      if (!rst && ifc.bus_rd && ifc.bus_ready) begin
        inflight = pend_due.size() + (ifc.bus_rvalid ? 1 : 0);
        chk("outstanding_limit", 32'(inflight < MAXO), 32'd1);
        if (exp_addr.size() == 0) chk("unexpected_bus_read", 32'd1, 32'd0);
        else chk("bus_addr", 32'(ifc.bus_addr), 32'(exp_addr.pop_front()));
        pend_addr.push_back(ifc.bus_addr);
        pend_due.push_back(cyc + lat + (jitter ? int'($urandom_range(0, 2)) : 0));
        rd_count++;
        if (inflight + 1 > max_inflight) max_inflight = inflight + 1;
      end
    end
  end

  // Returned-word monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && ifc.mem_rvalid) begin
        if (exp_data.size() == 0) chk("unexpected_mem_rvalid", 32'd1, 32'd0);
        else chk("mem_rdata", ifc.mem_rdata, exp_data.pop_front());
        if (rx_count == 0) rx_first = cyc;
        rx_last = cyc;
        rx_count++;
      end
    end
  end

  task automatic start_burst(input logic [29:0] addr, input logic [4:0] rlen, output int req_cyc);
    logic [29:0] b;
    b = addr & ~{25'd0, rlen};
    for (int i = 0; i <= int'(rlen); i++) begin
      exp_addr.push_back(b + 30'(i));
      exp_data.push_back(mem_word(b + 30'(i)));
    end
    rx_count = 0;
    rd_count = 0;
    max_inflight = 0;
    next_drive();
    req_cyc = cyc;
    ifc.mem_request = 1'b1;
    ifc.mem_addr    = addr;
    ifc.mem_rlen    = rlen;
    @(negedge clk);
    chk("ack_low_in_request_cycle", 32'(ifc.mem_ack), 32'd0);
    @(negedge clk);
    chk("ack_one_cycle_later", 32'(ifc.mem_ack), 32'd1);
    next_drive();
    ifc.mem_request = 1'b0;
    ifc.mem_addr    = 30'($urandom);
    ifc.mem_rlen    = 5'($urandom);
    @(negedge clk);
    chk("ack_single_pulse", 32'(ifc.mem_ack), 32'd0);
  endtask

  task automatic finish_burst(input int n, input int req_cyc, input bit check_timing);
    int t;
    t = 0;
    while (rx_count < n && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    repeat (4) @(negedge clk);
    chk("burst_word_count", 32'(rx_count), 32'(n));
    chk("bus_reads_issued", 32'(rd_count), 32'(n));
    chk("words_left_over", 32'(exp_data.size()), 32'd0);
    chk("no_spurious_flag", 32'(spurious_rvalid), 32'd0);
    if (check_timing) begin
      chk("first_word_latency", 32'(rx_first - req_cyc), 32'(lat + 2));
      chk("back_to_back_words", 32'(rx_last - rx_first), 32'(n - 1));
    end
    if (t >= 2000) begin
      exp_data.delete();
      exp_addr.delete();
    end
  endtask

  task automatic do_burst(input logic [29:0] addr, input logic [4:0] rlen, input bit check_timing);
    int rc;
    start_burst(addr, rlen, rc);
    finish_burst(int'(rlen) + 1, rc, check_timing);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_mem_ack"},    32'(ifc.mem_ack), 32'd0);
    chk({tag, "_mem_rvalid"}, 32'(ifc.mem_rvalid), 32'd0);
    chk({tag, "_mem_rdata"},  ifc.mem_rdata, 32'd0);
    chk({tag, "_bus_rd"},     32'(ifc.bus_rd), 32'd0);
    chk({tag, "_bus_addr"},   32'(ifc.bus_addr), 32'd0);
    chk({tag, "_spurious"},   32'(spurious_rvalid), 32'd0);
  endtask

  initial begin
    int rc;
    int t;
    int k;
    rst = 1'b1;
    ifc.mem_request = 1'b0;
    ifc.mem_addr    = '0;
    ifc.mem_rlen    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    next_drive();
    rst = 1'b0;

    // aligned burst, one-word-per-cycle throughput
    lat = 1; ready_mode = 0; jitter = 1'b0;
    do_burst(30'h100, 5'd7, 1'b1);

    // unaligned request starts at the line base
    do_burst(30'h10D, 5'd7, 1'b1);

    // outstanding limit
    lat = 6;
    do_burst(30'h2000, 5'd15, 1'b0);
    chk("max_in_flight", 32'(max_inflight), 32'(MAXO));

    // backpressure
    lat = 2; ready_mode = 1;
    do_burst(30'h55, 5'd3, 1'b0);

    // longest burst and single-word burst at the top address
    ready_mode = 0;
    do_burst(30'h1234_5678, 5'd31, 1'b1);
    do_burst(30'h3FFF_FFFF, 5'd0, 1'b1);

    // randomised bursts
    ready_mode = 2; jitter = 1'b1;
    for (int i = 0; i < 20; i++) begin
      lat = int'($urandom_range(1, 8));
      k = int'($urandom_range(0, 5));
      do_burst(30'($urandom), 5'((1 << k) - 1), 1'b0);
    end

    // stray backing data while idle
    ready_mode = 0; jitter = 1'b0; lat = 1;
    next_drive();
    inject_spur = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("spurious_set", 32'(spurious_rvalid), 32'd1);
    chk("spurious_dropped", 32'(ifc.mem_rvalid), 32'd0);
    @(negedge clk);
    chk("spurious_sticky", 32'(spurious_rvalid), 32'd1);

    // reset after three of eight words
    start_burst(30'h400, 5'd7, rc);
    t = 0;
    while (rx_count < 3 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("words_before_reset", 32'(rx_count), 32'd3);
    next_drive();
    rst = 1'b1;
    pend_addr.delete();
    pend_due.delete();
    next_drive();
    rst = 1'b0;
    exp_data.delete();
    exp_addr.delete();
    @(negedge clk);
    check_outputs_zero("after_mid_reset");
    do_burst(30'h777, 5'd7, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
